ddr3_rd_capture: RTL and testbench

DDR3_RD_CAPTURE -- requirements
Module: ddr3_rd_capture

---
 rtl/ddr3_rd_capture_if.sv | 29 ++
 rtl/ddr3_rd_capture.sv | 123 ++++++++++++
 tb/tb_ddr3_rd_capture.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_rd_capture_if.sv
// Read-capture bus: request/credit handshake, DFI read beats, chunk output and error flags.
interface ddr3_rd_capture_if #(
   parameter int DDR3_WIDTH = 16,
   parameter int TAG_BITS   = 4
);
   logic                    rd_req_i;
   logic [TAG_BITS-1:0]     rd_tag_i;
   logic                    rd_accept_o;
   logic                    dfi_rvld_i;
   logic                    dfi_last_i;
   logic [2*DDR3_WIDTH-1:0] dfi_data_i;
   logic                    rd_valid_o;
   logic                    rd_ready_i;
   logic [TAG_BITS-1:0]     rd_tag_o;
   logic [8*DDR3_WIDTH-1:0] rd_data_o;
   logic                    err_align_o;
   logic                    err_ovf_o;
   logic                    err_tag_o;

   modport slave (
      input  rd_req_i, rd_tag_i, dfi_rvld_i, dfi_last_i, dfi_data_i, rd_ready_i,
      output rd_accept_o, rd_valid_o, rd_tag_o, rd_data_o, err_align_o, err_ovf_o, err_tag_o
   );

   modport master (
      output rd_req_i, rd_tag_i, dfi_rvld_i, dfi_last_i, dfi_data_i, rd_ready_i,
      input  rd_accept_o, rd_valid_o, rd_tag_o, rd_data_o, err_align_o, err_ovf_o, err_tag_o
   );
endinterface

// File: rtl/ddr3_rd_capture.sv
// Assembles four DFI read beats into one BL8 chunk, tags it from a request FIFO and
// buffers it in a chunk FIFO; request credits track chunks not yet handed to the consumer.
module ddr3_rd_capture #(
   parameter int DDR3_WIDTH = 16,
   parameter int DEPTH      = 4,
   parameter int TAG_BITS   = 4
) (
   input logic              clock,
   input logic              reset_n,
   ddr3_rd_capture_if.slave bus
);
   localparam int BEAT_W  = 2 * DDR3_WIDTH;
   localparam int CHUNK_W = 8 * DDR3_WIDTH;
   localparam int AW      = $clog2(DEPTH);

   typedef logic [AW:0] ptr_t;
   localparam ptr_t ONE     = ptr_t'(1);
   localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

   function automatic logic is_full(input ptr_t wp, input ptr_t rp);
      return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   endfunction

   // Saturates at zero so a handshake of an untagged chunk cannot wrap the credit count.
   function automatic ptr_t credit_next(input ptr_t cur, input logic inc, input logic dec);
      ptr_t r;
      r = cur;
      if (inc && !dec)
         r = cur + ONE;
      else if (dec && !inc && (cur != '0))
         r = cur - ONE;
      return r;
   endfunction

   logic [1:0]           cnt_p0;
   logic [3*BEAT_W-1:0]  part_p0;
   logic [CHUNK_W-1:0]   chunk_w;
   logic                 beat, complete, align_err, req_acc, rd_hs;
   logic                 tag_empty, tag_full, tag_push, tag_pop;
   logic                 chk_empty, chk_full, chk_push, chk_ovf;
   logic [TAG_BITS-1:0]  tag_head;
   ptr_t                 tag_wp, tag_rp, chk_wp, chk_rp, used_q, used_nxt;
   logic                 accept_q, err_align_q, err_ovf_q, err_tag_q;

   logic [TAG_BITS-1:0]  tag_mem  [DEPTH];
   logic [CHUNK_W-1:0]   data_mem [DEPTH];
   logic [TAG_BITS-1:0]  ctag_mem [DEPTH];

   assign beat      = bus.dfi_rvld_i;
   assign complete  = beat && (cnt_p0 == 2'd3);
   assign align_err = beat && bus.dfi_last_i && (cnt_p0 != 2'd3);
   assign req_acc   = bus.rd_req_i && accept_q;

   assign tag_empty = (tag_wp == tag_rp);
   assign tag_full  = is_full(tag_wp, tag_rp);
   assign tag_push  = req_acc && !tag_full;
   assign tag_pop   = complete && !tag_empty;
   assign tag_head  = tag_empty ? '0 : tag_mem[tag_rp[AW-1:0]];

   assign chk_empty = (chk_wp == chk_rp);
   assign chk_full  = is_full(chk_wp, chk_rp);
   assign rd_hs     = !chk_empty && bus.rd_ready_i;
   // A full FIFO still takes the chunk when the consumer drains an entry on the same edge.
   assign chk_push  = complete && (!chk_full || rd_hs);
   assign chk_ovf   = complete && chk_full && !rd_hs;
   assign chunk_w   = {bus.dfi_data_i, part_p0};

   assign used_nxt  = credit_next(used_q, req_acc, rd_hs);

   // Stage p0: beat lanes 0..2 held until the fourth beat completes the chunk
   always_ff @(posedge clock) begin
      for (int i = 0; i < 3; i++)
         if (beat && (cnt_p0 == 2'(i)))
            part_p0[BEAT_W*i +: BEAT_W] <= bus.dfi_data_i;
   end

   always_ff @(posedge clock) begin
      if (tag_push)
         tag_mem[tag_wp[AW-1:0]] <= bus.rd_tag_i;
      if (chk_push) begin
         data_mem[chk_wp[AW-1:0]] <= chunk_w;
         ctag_mem[chk_wp[AW-1:0]] <= tag_head;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_p0      <= '0;
         tag_wp      <= '0;
         tag_rp      <= '0;
         chk_wp      <= '0;
         chk_rp      <= '0;
         used_q      <= '0;
         accept_q    <= 1'b0;
         err_align_q <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_tag_q   <= 1'b0;
      end else begin
         if (align_err)
            cnt_p0 <= '0;
         else if (beat)
            cnt_p0 <= cnt_p0 + 2'd1;
         if (tag_push) tag_wp <= tag_wp + ONE;
         if (tag_pop)  tag_rp <= tag_rp + ONE;
         if (chk_push) chk_wp <= chk_wp + ONE;
         if (rd_hs)    chk_rp <= chk_rp + ONE;
         used_q   <= used_nxt;
         accept_q <= (used_nxt < DEPTH_P);
         if (align_err)             err_align_q <= 1'b1;
         if (chk_ovf)               err_ovf_q   <= 1'b1;
         if (complete && tag_empty) err_tag_q   <= 1'b1;
      end
   end

   // Output stage: head of the chunk FIFO, zeroed while the FIFO is empty
   assign bus.rd_accept_o = accept_q;
   assign bus.rd_valid_o  = !chk_empty;
   assign bus.rd_data_o   = chk_empty ? '0 : data_mem[chk_rp[AW-1:0]];
   assign bus.rd_tag_o    = chk_empty ? '0 : ctag_mem[chk_rp[AW-1:0]];
   assign bus.err_align_o = err_align_q;
   assign bus.err_ovf_o   = err_ovf_q;
   assign bus.err_tag_o   = err_tag_q;
endmodule

// File: tb/tb_ddr3_rd_capture.sv
// Directed bench for ddr3_rd_capture: chunk assembly, credits, alignment, overflow, tagless and reset cases.
module tb_ddr3_rd_capture;
   localparam int W = 16;
   localparam int D = 4;
   localparam int T = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   ddr3_rd_capture_if #(.DDR3_WIDTH(W), .TAG_BITS(T)) bus ();

   ddr3_rd_capture #(.DDR3_WIDTH(W), .DEPTH(D), .TAG_BITS(T)) dut (
      .clock   (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.rd_req_i   = 1'b0;
      bus.rd_tag_i   = '0;
      bus.dfi_rvld_i = 1'b0;
      bus.dfi_last_i = 1'b0;
      bus.dfi_data_i = '0;
      bus.rd_ready_i = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset_n = 1'b0;
      #3;
      reset_n = 1'b1;
      tick();
   endtask

   task automatic request(input logic [T-1:0] tag);
      bus.rd_req_i = 1'b1;
      bus.rd_tag_i = tag;
      tick();
      bus.rd_req_i = 1'b0;
   endtask

   task automatic beat(input logic [31:0] data, input logic last);
      bus.dfi_rvld_i = 1'b1;
      bus.dfi_data_i = data;
      bus.dfi_last_i = last;
      tick();
      bus.dfi_rvld_i = 1'b0;
      bus.dfi_last_i = 1'b0;
   endtask

   initial begin
      idle();
      // reset state
      #2;
      chk("rst_accept", 1'(bus.rd_accept_o), 1'b0);
      chk("rst_valid",  1'(bus.rd_valid_o), 1'b0);
      chk("rst_tag",    128'(bus.rd_tag_o), 128'h0);
      chk("rst_data",   bus.rd_data_o, 128'h0);
      chk("rst_errs",   {bus.err_align_o, bus.err_ovf_o, bus.err_tag_o}, 3'b000);
      #1 reset_n = 1'b1;
      tick();
      chk("accept_after_rst", 1'(bus.rd_accept_o), 1'b1);

      // single tagged chunk
      request(4'h5);
      beat(32'h11111111, 1'b0);
      beat(32'h22222222, 1'b0);
      beat(32'h33333333, 1'b0);
      chk("valid_before_last", 1'(bus.rd_valid_o), 1'b0);
      beat(32'h44444444, 1'b1);
      chk("c1_valid", 1'(bus.rd_valid_o), 1'b1);
      chk("c1_tag",   128'(bus.rd_tag_o), 128'h5);
      chk("c1_data",  bus.rd_data_o, 128'h44444444_33333333_22222222_11111111);
      tick();
      chk("c1_hold_data", bus.rd_data_o, 128'h44444444_33333333_22222222_11111111);
      bus.rd_ready_i = 1'b1;
      tick();
      bus.rd_ready_i = 1'b0;
      chk("c1_drained", 1'(bus.rd_valid_o), 1'b0);
      chk("c1_no_err", {bus.err_align_o, bus.err_ovf_o, bus.err_tag_o}, 3'b000);

      // credit exhaustion
      do_reset();
      request(4'h1);
      request(4'h2);
      request(4'h3);
      chk("credit_3_used", 1'(bus.rd_accept_o), 1'b1);
      request(4'h4);
      chk("credit_full", 1'(bus.rd_accept_o), 1'b0);
      request(4'h6);
      chk("credit_5th_rejected", 1'(bus.rd_accept_o), 1'b0);
      beat(32'hA0000001, 1'b0);
      beat(32'hA0000002, 1'b0);
      beat(32'hA0000003, 1'b0);
      beat(32'hA0000004, 1'b1);
      chk("credit_chunk_tag", 128'(bus.rd_tag_o), 128'h1);
      chk("credit_still_full", 1'(bus.rd_accept_o), 1'b0);
      bus.rd_ready_i = 1'b1;
      tick();
      bus.rd_ready_i = 1'b0;
      chk("credit_restored", 1'(bus.rd_accept_o), 1'b1);

      // two chunks from one eight-beat burst
      do_reset();
      request(4'hA);
      request(4'hB);
      beat(32'hB0000001, 1'b0);
      beat(32'hB0000002, 1'b0);
      beat(32'hB0000003, 1'b0);
      beat(32'hB0000004, 1'b0);
      beat(32'hB0000005, 1'b0);
      beat(32'hB0000006, 1'b0);
      beat(32'hB0000007, 1'b0);
      beat(32'hB0000008, 1'b1);
      chk("b8_first_tag",  128'(bus.rd_tag_o), 128'hA);
      chk("b8_first_data", bus.rd_data_o, 128'hB0000004_B0000003_B0000002_B0000001);
      bus.rd_ready_i = 1'b1;
      tick();
      chk("b8_second_valid", 1'(bus.rd_valid_o), 1'b1);
      chk("b8_second_tag",  128'(bus.rd_tag_o), 128'hB);
      chk("b8_second_data", bus.rd_data_o, 128'hB0000008_B0000007_B0000006_B0000005);
      tick();
      bus.rd_ready_i = 1'b0;
      chk("b8_drained", 1'(bus.rd_valid_o), 1'b0);
      chk("b8_no_err", {bus.err_align_o, bus.err_ovf_o, bus.err_tag_o}, 3'b000);

      // short burst then good burst
      do_reset();
      request(4'h7);
      beat(32'hDEAD0001, 1'b0);
      beat(32'hDEAD0002, 1'b1);
      chk("align_err", 1'(bus.err_align_o), 1'b1);
      chk("align_no_chunk", 1'(bus.rd_valid_o), 1'b0);
      beat(32'h55550001, 1'b0);
      beat(32'h55550002, 1'b0);
      beat(32'h55550003, 1'b0);
      beat(32'h55550004, 1'b1);
      chk("align_recover_valid", 1'(bus.rd_valid_o), 1'b1);
      chk("align_recover_tag",  128'(bus.rd_tag_o), 128'h7);
      chk("align_recover_data", bus.rd_data_o, 128'h55550004_55550003_55550002_55550001);
      chk("align_sticky", 1'(bus.err_align_o), 1'b1);
      chk("align_no_tag_err", 1'(bus.err_tag_o), 1'b0);

      // chunk with no pending tag
      do_reset();
      beat(32'hC0000001, 1'b0);
      beat(32'hC0000002, 1'b0);
      beat(32'hC0000003, 1'b0);
      beat(32'hC0000004, 1'b1);
      chk("notag_valid", 1'(bus.rd_valid_o), 1'b1);
      chk("notag_tag",   128'(bus.rd_tag_o), 128'h0);
      chk("notag_data",  bus.rd_data_o, 128'hC0000004_C0000003_C0000002_C0000001);
      chk("notag_err",   1'(bus.err_tag_o), 1'b1);
      bus.rd_ready_i = 1'b1;
      tick();
      bus.rd_ready_i = 1'b0;
      chk("notag_credit_ok", 1'(bus.rd_accept_o), 1'b1);

      // overflow and simultaneous write/read when full
      do_reset();
      for (int c = 0; c < 4; c++)
         for (int l = 0; l < 4; l++)
            beat(32'(c * 16 + l), 1'b0);
      chk("full_no_ovf", 1'(bus.err_ovf_o), 1'b0);
      chk("full_head", bus.rd_data_o, 128'h00000003_00000002_00000001_00000000);
      for (int l = 0; l < 3; l++)
         beat(32'(64 + l), 1'b0);
      bus.rd_ready_i = 1'b1;
      beat(32'h43, 1'b0);
      bus.rd_ready_i = 1'b0;
      chk("wr_rd_full_no_ovf", 1'(bus.err_ovf_o), 1'b0);
      chk("wr_rd_full_head", bus.rd_data_o, 128'h00000013_00000012_00000011_00000010);
      for (int l = 0; l < 4; l++)
         beat(32'(80 + l), 1'b0);
      chk("ovf_set", 1'(bus.err_ovf_o), 1'b1);
      chk("ovf_head_kept", bus.rd_data_o, 128'h00000013_00000012_00000011_00000010);

      // reset during the second beat of a burst
      do_reset();
      beat(32'hE0000001, 1'b0);
      beat(32'hE0000002, 1'b0);
      beat(32'hE0000003, 1'b0);
      beat(32'hE0000004, 1'b0);
      chk("pre_rst_valid", 1'(bus.rd_valid_o), 1'b1);
      request(4'h3);
      beat(32'hF0000001, 1'b0);
      bus.dfi_rvld_i = 1'b1;
      bus.dfi_data_i = 32'hF0000002;
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_valid",  1'(bus.rd_valid_o), 1'b0);
      chk("midrst_accept", 1'(bus.rd_accept_o), 1'b0);
      chk("midrst_data",   bus.rd_data_o, 128'h0);
      chk("midrst_errs",   {bus.err_align_o, bus.err_ovf_o, bus.err_tag_o}, 3'b000);
      idle();
      #1 reset_n = 1'b1;
      tick();
      tick();
      chk("postrst_no_stale", 1'(bus.rd_valid_o), 1'b0);
      chk("postrst_accept", 1'(bus.rd_accept_o), 1'b1);
      request(4'h9);
      beat(32'h90000001, 1'b0);
      beat(32'h90000002, 1'b0);
      beat(32'h90000003, 1'b0);
      chk("postrst_aligned", 1'(bus.rd_valid_o), 1'b0);
      beat(32'h90000004, 1'b1);
      chk("postrst_tag",  128'(bus.rd_tag_o), 128'h9);
      chk("postrst_data", bus.rd_data_o, 128'h90000004_90000003_90000002_90000001);
      chk("postrst_errs", {bus.err_align_o, bus.err_ovf_o, bus.err_tag_o}, 3'b000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
